// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: plays a stored {pattern, duration} program on a prescaled tick, heartbeat count when idle.
// led_out updates one cycle after a tick or accepted start; cfg_ready drops in RUN and writes offered then are dropped.
module led_seq_ctrl #(
  parameter int CLK_FREQ = 50000000,
  parameter int TICK_HZ  = 10,
  parameter int DEPTH    = 8,
  parameter int DUR_W    = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [3:0]       cfg_pattern,
  input  logic [DUR_W-1:0] cfg_dur,
  input  logic [AW:0]      seq_len,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [3:0]       led_out
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0]    DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);
  localparam logic [AW:0]      DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0]      LEN_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0]    IDX_ONE = AW'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [AW:0]      len_q, len_d;
  logic             loop_q, loop_d;
  logic [3:0]       led_q, led_d;
  logic             done_q, done_d;
  logic [3:0]       pat_q [DEPTH];
  logic [3:0]       pat_d [DEPTH];
  logic [DUR_W-1:0] dur_q [DEPTH];
  logic [DUR_W-1:0] dur_d [DEPTH];

  logic          tick;
  logic          wr_fire;
  logic          start_ok;
  logic          last_step;
  logic [AW-1:0] idx_nxt;

  // A zero duration is played as a single tick.
  function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_ONE : d;
  endfunction

  assign tick      = (cnt_q == DIV_M1);
  assign cfg_ready = (state_q == ST_IDLE);
  assign wr_fire   = cfg_valid && cfg_ready;
  assign start_ok  = start && !stop && (seq_len != '0);
  assign idx_nxt   = idx_q + IDX_ONE;
  assign last_step = (({1'b0, idx_q} + LEN_ONE) == len_q);

  assign busy    = (state_q == ST_RUN);
  assign done    = done_q;
  assign led_out = led_q;

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_ONE;
  end

  always_comb begin
    pat_d = pat_q;
    dur_d = dur_q;
    if (wr_fire) begin
      pat_d[cfg_addr] = cfg_pattern;
      dur_d[cfg_addr] = cfg_dur;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    len_d   = len_q;
    loop_d  = loop_q;
    led_d   = led_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          len_d   = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
          loop_d  = loop;
          idx_d   = '0;
          rem_d   = eff_dur(dur_q[0]);
          led_d   = pat_q[0];
          state_d = ST_RUN;
        end else if (tick) begin
          led_d = led_q + 4'd1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (rem_q > DUR_ONE) begin
            rem_d = rem_q - DUR_ONE;
          end else if (!last_step) begin
            idx_d = idx_nxt;
            led_d = pat_q[idx_nxt];
            rem_d = eff_dur(dur_q[idx_nxt]);
          end else if (loop_q) begin
            idx_d = '0;
            led_d = pat_q[0];
            rem_d = eff_dur(dur_q[0]);
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      led_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pat_q[i] <= '0;
        dur_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      led_q   <= led_d;
      done_q  <= done_d;
      pat_q   <= pat_d;
      dur_q   <= dur_d;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl at DIV=4: expected per-cycle {led, busy, done, ready}
// tuples are queued with each stimulus step and popped as the DUT is sampled 1 time unit after each edge.
module tb_led_seq_ctrl;

  localparam int AW = 3;

  typedef struct packed {
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic       rdy;
  } obs_t;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [3:0]    cfg_pattern;
  logic [7:0]    cfg_dur;
  logic [AW:0]   seq_len;
  logic          loop;
  logic          start;
  logic          stop;
  logic          busy;
  logic          done;
  logic [3:0]    led_out;

  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  obs_t exp_q[$];

  led_seq_ctrl #(.CLK_FREQ(8), .TICK_HZ(2), .DEPTH(8), .DUR_W(8)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_pattern(cfg_pattern),
    .cfg_dur    (cfg_dur),
    .seq_len    (seq_len),
    .loop       (loop),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .done       (done),
    .led_out    (led_out)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic obs_t cur_obs();
    obs_t o;
    o.led  = led_out;
    o.busy = busy;
    o.done = done;
    o.rdy  = cfg_ready;
    return o;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
    k++;
  endtask

  task automatic cmp(input string tag, input int n, input obs_t got, input obs_t exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s[%0d]: observed led=%h busy=%b done=%b rdy=%b, expected led=%h busy=%b done=%b rdy=%b",
             tag, n, got.led, got.busy, got.done, got.rdy, exp.led, exp.busy, exp.done, exp.rdy);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] led, input logic b, input logic d, input int n);
    obs_t e;
    e.led  = led;
    e.busy = b;
    e.done = d;
    e.rdy  = ~b;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Advance n edges; start/stop are one-shot pulses cleared after each edge.
  task automatic run_sb(input string tag, input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      step();
      start = 1'b0;
      stop  = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s[%0d]: observed output with no expected entry queued", tag, i);
      end else begin
        e = exp_q.pop_front();
        cmp(tag, i, cur_obs(), e);
      end
    end
  endtask

  task automatic wr(input int addr, input logic [3:0] pat, input logic [7:0] dur);
    cfg_valid   = 1'b1;
    cfg_addr    = AW'(addr);
    cfg_pattern = pat;
    cfg_dur     = dur;
    step();
    cfg_valid   = 1'b0;
  endtask

  // Arrange for the start to be taken on a tick edge so step timing is exact.
  task automatic align_start(input int len, input logic lp);
    while ((k % 4) != 3) step();
    seq_len = (AW + 1)'(len);
    loop    = lp;
    start   = 1'b1;
  endtask

  task automatic push_basic_run();
    push(4'hA, 1'b1, 1'b0, 4);
    push(4'h5, 1'b1, 1'b0, 8);
    push(4'hF, 1'b1, 1'b0, 12);
    push(4'hF, 1'b0, 1'b1, 1);
    push(4'hF, 1'b0, 1'b0, 3);
    push(4'h0, 1'b0, 1'b0, 1);
  endtask

  initial begin
    obs_t rst_exp;
    sys_rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_addr = '0;
    cfg_pattern = '0;
    cfg_dur = '0;
    seq_len = '0;
    loop = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    rst_exp.led = 4'h0;
    rst_exp.busy = 1'b0;
    rst_exp.done = 1'b0;
    rst_exp.rdy = 1'b1;

    // Reset and heartbeat wrap
    repeat (3) step();
    cmp("reset", 0, cur_obs(), rst_exp);
    sys_rst = 1'b0;
    k = 0;
    for (int i = 1; i <= 64; i++) push(4'((i >> 2) & 15), 1'b0, 1'b0, 1);
    run_sb("heartbeat", 64);

    // Single non-looping run
    wr(0, 4'hA, 8'd1);
    wr(1, 4'h5, 8'd2);
    wr(2, 4'hF, 8'd3);
    align_start(3, 1'b0);
    push_basic_run();
    run_sb("single_run", 29);

    // Looping run, stopped while 5 is showing
    align_start(3, 1'b1);
    push(4'hA, 1'b1, 1'b0, 4);
    push(4'h5, 1'b1, 1'b0, 8);
    push(4'hF, 1'b1, 1'b0, 12);
    push(4'hA, 1'b1, 1'b0, 4);
    push(4'h5, 1'b1, 1'b0, 2);
    run_sb("loop_run", 30);
    stop = 1'b1;
    push(4'h5, 1'b0, 1'b0, 2);
    push(4'h6, 1'b0, 1'b0, 1);
    run_sb("loop_stop", 3);

    // Write offered during RUN is dropped
    align_start(3, 1'b0);
    push_basic_run();
    run_sb("wr_run", 1);
    cfg_valid   = 1'b1;
    cfg_addr    = '0;
    cfg_pattern = 4'h3;
    cfg_dur     = 8'd9;
    run_sb("wr_run", 10);
    cfg_valid   = 1'b0;
    run_sb("wr_run", 18);
    align_start(1, 1'b0);
    push(4'hA, 1'b1, 1'b0, 4);
    push(4'hA, 1'b0, 1'b1, 1);
    push(4'hA, 1'b0, 1'b0, 3);
    push(4'hB, 1'b0, 1'b0, 1);
    run_sb("replay", 9);

    // Rejected starts
    seq_len = '0;
    start   = 1'b1;
    step();
    start   = 1'b0;
    chk_bit("len0_busy", busy, 1'b0);
    chk_bit("len0_rdy", cfg_ready, 1'b1);
    seq_len = 4'd3;
    start   = 1'b1;
    stop    = 1'b1;
    step();
    start   = 1'b0;
    stop    = 1'b0;
    chk_bit("start_stop_busy", busy, 1'b0);
    step();
    chk_bit("start_stop_busy2", busy, 1'b0);

    // Full-depth program with a zero-duration step, seq_len clamped to 8
    for (int i = 0; i < 8; i++) wr(i, 4'(i + 3), (i == 1) ? 8'd0 : 8'd1);
    align_start(12, 1'b0);
    for (int i = 0; i < 8; i++) push(4'(i + 3), 1'b1, 1'b0, 4);
    push(4'hA, 1'b0, 1'b1, 1);
    push(4'hA, 1'b0, 1'b0, 3);
    push(4'hB, 1'b0, 1'b0, 1);
    run_sb("clamp_run", 37);

    // Reset during step 1 of a looping program clears the store
    align_start(3, 1'b1);
    push(4'h3, 1'b1, 1'b0, 4);
    push(4'h4, 1'b1, 1'b0, 1);
    run_sb("mid_run", 5);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    k = 0;
    cmp("mid_reset", 0, cur_obs(), rst_exp);
    align_start(1, 1'b0);
    push(4'h0, 1'b1, 1'b0, 4);
    push(4'h0, 1'b0, 1'b1, 1);
    push(4'h0, 1'b0, 1'b0, 3);
    push(4'h1, 1'b0, 1'b0, 1);
    run_sb("post_reset", 9);

    checks++;
    assert (exp_q.size() == 0)
    else begin
      errors++;
      $error("FAIL sb_drain: observed %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Sequencing controller for the 4-bit LED bank. It stores a short programmable pattern program (pattern plus duration per step) and plays it out on a prescaled time base. A host loads the program over a valid/ready write port and starts or stops playback. When no program is running, it drives a free-running heartbeat count on the LEDs.

## Interface
- CLK_FREQ, 50000000: sys_clk frequency in Hz.
- TICK_HZ, 10: step time-base rate in Hz. DIV = CLK_FREQ/TICK_HZ, and DIV must be ≥ 2.
- DEPTH, 8: number of program steps. Power of 2, ≥ 2. AW = log2(DEPTH).
- DUR_W, 8: width of the per-step duration field, in ticks.

Ports:
- sys_clk  in  1  clock; all logic on the rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- cfg_valid  in  1  program write request.
- cfg_ready  out  1  write accept. A write occurs on cfg_valid && cfg_ready.
- cfg_addr  in  AW  step index to write.
- cfg_pattern  in  4  LED pattern for the step.
- cfg_dur  in  DUR_W  step duration in ticks.
- seq_len  in  AW+1  number of steps to play; sampled on an accepted start.
- loop  in  1  repeat enable; sampled on an accepted start.
- start  in  1  begin playback (level is sampled each cycle).
- stop  in  1  abort playback.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a non-looping program completes.
- led_out  out  4  LED drive.

## Operation
- **Prescaler:** a free-running counter counts 0..DIV-1 and wraps. Internal tick is high for one cycle when the counter equals DIV-1. Only sys_rst clears it; start and stop do not.
- **Program store:** DEPTH entries of {pattern[3:0], dur[DUR_W-1:0]}, all cleared to 0 by sys_rst.
  - cfg_ready = 1 in IDLE and 0 in RUN. Writes attempted in RUN are dropped.
- **States:** IDLE and RUN.
- **IDLE:**
  - led_out increments by 1 (mod 16) on each tick.
  - An accepted start requires start=1, stop=0 and seq_len≠0. It latches len = min(seq_len, DEPTH) and latches loop.
  - On an accepted start: idx←0, rem←max(dur[0],1), led_out←pattern[0], state←RUN.
  - start with seq_len=0, or start and stop in the same cycle, is ignored.
- **RUN:**
  - stop has priority over everything. On stop: state←IDLE, no done, led_out holds its current value.
  - On a tick with rem>1: rem←rem-1.
  - On a tick with rem≤1 and idx<len-1: idx←idx+1, led_out←pattern[idx+1], rem←max(dur[idx+1],1).
  - On a tick with rem≤1 and idx=len-1:
    - If loop=1: idx←0, led_out←pattern[0], rem←max(dur[0],1).
    - If loop=0: state←IDLE, done←1 for one cycle, led_out holds the last pattern.
  - start in RUN is ignored.
- **Duration semantics:** dur=0 behaves as 1. The first tick after entering a step may be partial, so a step lasts between dur-1 and dur tick periods plus up to DIV cycles. A step entered through the loop wrap or a tick advance lasts exactly max(dur,1)·DIV cycles.
- **Heartbeat resume:** after stop or done, the heartbeat resumes from the held led_out value on the next tick.

## Timing
- **Reset values:** led_out=0, busy=0, done=0, cfg_ready=1. Prescaler, idx, rem and state are cleared (state=IDLE). Reset mid-RUN takes full effect at the next edge.
- **Start latency:** start accepted at edge N → busy=1, cfg_ready=0 and led_out=pattern[0] after edge N.
- **Step advance:** tick high in cycle T → the new led_out is visible after the edge ending cycle T, so there is 1 cycle of latency from tick.
- **Completion:** done and the busy fall occur on the same edge. done is high for exactly one cycle.
- **Stop latency:** stop at edge N → busy=0 and cfg_ready=1 after edge N.
- **Write acceptance:** a write is accepted on the edge where cfg_valid && cfg_ready is true, and is readable by playback from the next cycle.

## Test plan
All scenarios use CLK_FREQ=8, TICK_HZ=2 (DIV=4), DEPTH=8, DUR_W=8.
1. **Reset and heartbeat:** hold sys_rst for 3 cycles, then release → led_out=0, busy=0, cfg_ready=1. tick occurs every 4 cycles, and led_out steps 1,2,…,15,0, wrapping at 16.
2. **Single non-looping run:** write (0:A,1), (1:5,2), (2:F,3), then start with seq_len=3, loop=0.
   - led_out=A the cycle after start, then 5 for exactly 8 cycles, then F for 12 cycles.
   - Then done pulses for 1 cycle and busy=0. led_out holds F, then shows 0 on the next tick.
3. **Loop and stop:** same program with loop=1 → led_out plays A,5,F,A,5,…. Assert stop while 5 is showing → busy=0 the next cycle, no done, led_out stays 5, cfg_ready=1.
4. **Write during RUN:** while busy, drive cfg_valid with (0:3,9) → cfg_ready=0 and the write is dropped. After done, a replay still shows A at step 0.
5. **Edge cases:**
   - start with seq_len=0 → stays in IDLE.
   - start and stop in the same cycle → stays in IDLE.
   - Step with dur=0 → lasts 1 tick.
   - seq_len=12 → plays 8 steps, then done.
6. **Reset mid-run:** assert sys_rst during step 1 of a looping program → next cycle led_out=0, busy=0, done=0. A subsequent start with seq_len=1 shows pattern 0, confirming the store was cleared.
